// File: rtl/bttn_event_arbiter.sv
// Panel button front end: synchronizes and debounces four buttons, times reset/test holds on a
// shared 1 s divider, and hands pending events to the consumer one at a time over valid/ready.
module bttn_event_arbiter #(
    parameter int unsigned TICK_CYCLES     = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RST_HOLD_S      = 5,
    parameter int unsigned TEST_HOLD_S     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       botonReset,
    input  logic       botonTest,
    input  logic       botonA,
    input  logic       botonB,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       evt_drop,
    output logic [3:0] hold_sec,
    output logic       tick_1s
);

    localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       RstThr   = 4'(RST_HOLD_S);
    localparam logic [3:0]       TestThr  = 4'(TEST_HOLD_S);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    // Source index: 0 reset, 1 test, 2 A, 3 B (also the pending-slot order)
    logic [3:0]      raw;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      db_q, db_d, press;
    logic [DebW-1:0] deb_cnt_q [4];
    logic [DebW-1:0] deb_cnt_d [4];

    logic [TickW-1:0] div_q, div_d;
    logic             tick;

    logic [3:0] sec_q [2];
    logic [3:0] sec_d [2];
    logic [3:0] hold_thr [2];
    logic [1:0] fired_q, fired_d, fire;

    logic [3:0] pend_q, pend_d, set, grant;
    logic       drop_q, drop_d;
    state_e     state_q, state_d;
    logic       valid_q, valid_d;
    logic [2:0] code_q, code_d;

    assign raw         = {botonB, botonA, botonTest, botonReset};
    assign hold_thr[0] = RstThr;
    assign hold_thr[1] = TestThr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        db_d  = db_q;
        press = '0;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    db_d[i]  = sync2_q[i];
                    press[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_q <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            db_q <= db_d;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    assign tick  = (div_q == TickLast);
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_q <= '0;
        else      div_q <= div_d;
    end

    // A press edge clears the count even if a tick lands in the same cycle
    always_comb begin
        fired_d = fired_q;
        fire    = '0;
        for (int j = 0; j < 2; j++) begin
            sec_d[j] = sec_q[j];
            if (press[j]) begin
                sec_d[j] = '0;
            end else if (!db_q[j]) begin
                sec_d[j]   = '0;
                fired_d[j] = 1'b0;
            end else if (tick) begin
                if (sec_q[j] != 4'hF) sec_d[j] = sec_q[j] + 4'd1;
                if ((sec_d[j] == hold_thr[j]) && !fired_q[j]) begin
                    fire[j]    = 1'b1;
                    fired_d[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fired_q <= '0;
            sec_q[0] <= '0;
            sec_q[1] <= '0;
        end else begin
            fired_q <= fired_d;
            sec_q[0] <= sec_d[0];
            sec_q[1] <= sec_d[1];
        end
    end

    assign set = {press[3], press[2], fire[1], fire[0]};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        grant   = '0;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                code_d  = 3'd0;
                if (|pend_q) begin
                    state_d = StPresent;
                    valid_d = 1'b1;
                    if (pend_q[0]) begin
                        code_d   = 3'd1;
                        grant[0] = 1'b1;
                    end else if (pend_q[1]) begin
                        code_d   = 3'd2;
                        grant[1] = 1'b1;
                    end else if (pend_q[2]) begin
                        code_d   = 3'd3;
                        grant[2] = 1'b1;
                    end else begin
                        code_d   = 3'd4;
                        grant[3] = 1'b1;
                    end
                end
            end
            StPresent: begin
                if (evt_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    code_d  = 3'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A set on a slot being granted this cycle refills it rather than counting as a loss
    assign pend_d = (pend_q & ~grant) | set;
    assign drop_d = |(set & pend_q & ~grant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            code_q  <= 3'd0;
            pend_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign evt_drop  = drop_q;
    assign hold_sec  = db_q[0] ? sec_q[0] : 4'd0;
    assign tick_1s   = tick;

endmodule

// File: tb/tb_bttn_event_arbiter.sv
// Directed bench for bttn_event_arbiter with short tick/debounce timing.
module tb_bttn_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       botonReset = 1'b0;
    logic       botonTest = 1'b0;
    logic       botonA = 1'b0;
    logic       botonB = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_drop;
    logic [3:0] hold_sec;
    logic       tick_1s;

    int n_chk  = 0;
    int n_pass = 0;

    bttn_event_arbiter #(
        .TICK_CYCLES    (20),
        .DEBOUNCE_CYCLES(4),
        .RST_HOLD_S     (5),
        .TEST_HOLD_S    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .botonReset(botonReset),
        .botonTest (botonTest),
        .botonA    (botonA),
        .botonB    (botonB),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_drop  (evt_drop),
        .hold_sec  (hold_sec),
        .tick_1s   (tick_1s)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: botonReset = v;
            1: botonTest  = v;
            2: botonA     = v;
            default: botonB = v;
        endcase
    endtask

    task automatic pulse_btn(input int which, input int hold, input int gap,
                             output int drops, output int valids, output int last_code);
        drops = 0; valids = 0; last_code = 0;
        set_btn(which, 1'b1);
        for (int i = 0; i < hold + gap; i++) begin
            if (i == hold) set_btn(which, 1'b0);
            step(1);
            drops += int'(evt_drop);
            if (evt_valid) begin
                valids++;
                last_code = int'(evt_code);
            end
        end
    endtask

    task automatic wait_valid(input int max, output int ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (evt_valid) begin
                ok = 1;
                break;
            end
            step(1);
        end
    endtask

    task automatic wait_hold(input int v, input int max, output int ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (int'(hold_sec) == v) begin
                ok = 1;
                break;
            end
            step(1);
        end
    endtask

    initial begin
        int n, ok, t, cur, prev, mx, bad, n_any, n_rst, sec_evt, unstable, ndrop, k, adj, pv;
        int d1, d2, d3, v, lc, wrong;
        int codes [4];

        // Reset state
        #2 rst = 1'b0;
        step(3);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_code", int'(evt_code), 0);
        chk("rst_drop", int'(evt_drop), 0);
        chk("rst_hold", int'(hold_sec), 0);
        chk("rst_tick", int'(tick_1s), 0);
        rst = 1'b1;

        // Divider: first tick 19 edges after release, then every 20
        t = 0;
        while (!tick_1s && t < 40) begin step(1); t++; end
        chk("first_tick", t, 19);
        t = 0;
        do begin step(1); t++; end while (!tick_1s && t < 40);
        chk("tick_period", t, 20);

        // 1. Glitch rejected, held press gives one A event 7 cycles after raw edge
        botonA = 1'b1;
        step(3);
        botonA = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin step(1); n += int'(evt_valid); end
        chk("glitch_no_evt", n, 0);
        botonA = 1'b1;
        step(6);
        chk("a_not_yet", int'(evt_valid), 0);
        step(1);
        chk("a_valid_at_7", int'(evt_valid), 1);
        chk("a_code", int'(evt_code), 3);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) botonA = 1'b0;
            step(1);
            n += int'(evt_valid);
        end
        chk("a_single", n, 0);

        // 2. Long reset hold
        botonReset = 1'b1;
        prev = 0; mx = 0; bad = 0; n_any = 0; n_rst = 0; sec_evt = -1;
        for (int i = 0; i < 140; i++) begin
            if (i == 120) botonReset = 1'b0;
            step(1);
            cur = int'(hold_sec);
            if (cur != prev && cur != prev + 1 && cur != 0) bad++;
            prev = cur;
            if (cur > mx) mx = cur;
            if (evt_valid) begin
                n_any++;
                if (evt_code == 3'd1) begin n_rst++; sec_evt = cur; end
            end
        end
        chk("rsthold_steps", bad, 0);
        chk("rsthold_max_ok", int'(mx >= 5 && mx <= 6), 1);
        chk("rsthold_one_evt", n_rst, 1);
        chk("rsthold_only_evt", n_any, 1);
        chk("rsthold_fire_at5", sec_evt, 5);
        chk("rsthold_released", int'(hold_sec), 0);

        // 3. Early release: no event, re-press restarts from 0
        n = 0;
        botonReset = 1'b1;
        wait_hold(3, 100, ok);
        chk("early_reach3", ok, 1);
        botonReset = 1'b0;
        for (int i = 0; i < 20; i++) begin step(1); n += int'(evt_valid); end
        chk("early_hold0", int'(hold_sec), 0);
        botonReset = 1'b1;
        step(6);
        chk("repress_zero", int'(hold_sec), 0);
        wait_hold(1, 25, ok);
        chk("repress_reach1", ok, 1);
        botonReset = 1'b0;
        for (int i = 0; i < 15; i++) begin step(1); n += int'(evt_valid); end
        chk("early_no_evt", n, 0);

        // 4. Back-pressure ordering
        evt_ready = 1'b0;
        botonA = 1'b1;
        wait_valid(20, ok);
        chk("bp_first_valid", ok, 1);
        chk("bp_first_code", int'(evt_code), 3);
        unstable = 0; ndrop = 0;
        for (int i = 0; i < 130; i++) begin
            if (i == 5) botonA = 1'b0;
            if (i == 20) botonB = 1'b1;
            if (i == 30) botonB = 1'b0;
            if (i == 40) botonTest = 1'b1;
            if (i == 115) botonTest = 1'b0;
            step(1);
            if (!(evt_valid && evt_code == 3'd3)) unstable++;
            ndrop += int'(evt_drop);
        end
        chk("bp_stable", unstable, 0);
        chk("bp_no_drop", ndrop, 0);
        evt_ready = 1'b1;
        k = 0; adj = 0; pv = 0;
        for (int i = 0; i < 12; i++) begin
            if (evt_valid) begin
                if (k < 4) codes[k] = int'(evt_code);
                k++;
                if (pv != 0) adj++;
            end
            pv = int'(evt_valid);
            step(1);
        end
        chk("bp_count", k, 3);
        chk("bp_code0", codes[0], 3);
        chk("bp_code1", codes[1], 2);
        chk("bp_code2", codes[2], 4);
        chk("bp_gap", adj, 0);

        // 5. Slot overflow
        evt_ready = 1'b0;
        pulse_btn(2, 10, 15, d1, v, lc);
        chk("ovf_present", int'(evt_valid && evt_code == 3'd3), 1);
        pulse_btn(2, 10, 15, d2, v, lc);
        chk("ovf_no_drop_early", d1 + d2, 0);
        pulse_btn(2, 10, 15, d3, v, lc);
        chk("ovf_drop_once", d3, 1);
        evt_ready = 1'b1;
        n = 0; wrong = 0;
        for (int i = 0; i < 12; i++) begin
            if (evt_valid) begin
                n++;
                if (evt_code != 3'd3) wrong++;
            end
            step(1);
        end
        chk("ovf_two_a", n, 2);
        chk("ovf_codes", wrong, 0);

        // 6. Asynchronous reset mid-operation
        evt_ready = 1'b0;
        botonTest = 1'b1;
        botonReset = 1'b1;
        botonA = 1'b1;
        wait_valid(20, ok);
        chk("mid_valid", ok, 1);
        wait_hold(1, 40, ok);
        chk("mid_hold1", ok, 1);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_valid", int'(evt_valid), 0);
        chk("mid_rst_hold", int'(hold_sec), 0);
        chk("mid_rst_code", int'(evt_code), 0);
        botonTest = 1'b0;
        botonReset = 1'b0;
        botonA = 1'b0;
        step(3);
        rst = 1'b1;
        evt_ready = 1'b1;
        n = 0; mx = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            n += int'(evt_valid);
            if (int'(hold_sec) > mx) mx = int'(hold_sec);
        end
        chk("post_rst_no_evt", n, 0);
        chk("post_rst_hold", mx, 0);
        pulse_btn(3, 10, 15, d1, v, lc);
        chk("post_rst_b_evt", v, 1);
        chk("post_rst_b_code", lc, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bttn_event_arbiter.md
Name: bttn_event_arbiter

Overview:
Front-end controller for the four panel buttons (reset, test, A, B). All button timing shares one 1 s time base. Each button is synchronized and debounced, and reset/test are timed for long holds. The block arbitrates pending events by fixed priority and hands them one at a time to the game FSM over a valid/ready handshake. It replaces the per-button dividers and state machines with one shared scheduler.

Parameters:
TICK_CYCLES, 50000000, clk cycles per 1 s tick (range 2..2^26).
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (range 1..2^20).
RST_HOLD_S, 5, hold seconds for the RESET_HOLD event (range 1..14).
TEST_HOLD_S, 5, hold seconds for the TEST_HOLD event (range 1..14).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
botonReset  in  1  raw reset button, 1 = pressed, asynchronous
botonTest  in  1  raw test button, 1 = pressed, asynchronous
botonA  in  1  raw action A button, 1 = pressed, asynchronous
botonB  in  1  raw action B button, 1 = pressed, asynchronous
evt_ready  in  1  consumer accepts the presented event
evt_valid  out  1  event presented
evt_code  out  3  0 none, 1 RESET_HOLD, 2 TEST_HOLD, 3 BTN_A, 4 BTN_B
evt_drop  out  1  one-cycle pulse: an event was lost because its pending slot was full
hold_sec  out  4  seconds the debounced reset button has been held, saturating at 15; 0 when released
tick_1s  out  1  one-cycle pulse from the shared divider

Behaviour:
- Reset (rst=0, async): all outputs 0; divider, debounce and hold counters 0; debounced levels 0 (released); pending bits 0; FSM in IDLE. Release is sampled on a clk edge.
- Synchronizer: each raw input passes through 2 flops before any logic.
- Debounce, per button:
  - A counter runs while the synced level differs from the debounced level.
  - The counter clears when the levels match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Raw-to-debounced latency is exactly 2+DEBOUNCE_CYCLES cycles.
- Divider: free-running counter 0..TICK_CYCLES-1. tick_1s=1 in the cycle the counter equals TICK_CYCLES-1, then the counter wraps to 0. It never restarts on button activity.
- Hold timing, reset and test only:
  - The 4-bit second counter clears on the debounced press edge.
  - It increments on each tick_1s while pressed and saturates at 15.
  - When it first equals the HOLD_S value, the button's pending bit is set once. A per-button fired flag blocks re-firing until debounced release.
  - Accuracy is within 1 s: the fire occurs between (HOLD_S-1)*TICK_CYCLES+1 and HOLD_S*TICK_CYCLES cycles after the debounced press.
  - A release before the threshold produces no event.
  - hold_sec mirrors the reset counter and reads 0 while released.
- A/B: the debounced press edge sets the pending bit. A release produces nothing.
- Pending slots: one bit per source.
  - Set while already set: the bit stays 1 and evt_drop pulses in that cycle.
  - Set and grant in the same cycle on the same bit: the set wins (bit stays 1, no drop).
- Arbiter FSM:
  - IDLE: if any pending bit is set, register the highest-priority code (RESET_HOLD > TEST_HOLD > BTN_A > BTN_B), clear that bit, assert evt_valid and go to PRESENT. Otherwise evt_valid=0 and evt_code=0.
  - PRESENT: evt_valid and evt_code are held stable until evt_ready=1, even if a higher-priority event arrives. On the handshake cycle go to IDLE; evt_valid deasserts in the next cycle.
  - Back-to-back events therefore have a minimum 1-cycle bubble (valid at most every 2 cycles).
  - Latency: pending set in cycle N -> evt_valid=1 in cycle N+1 at the earliest.
- evt_ready is ignored when evt_valid=0.
- Reset mid-operation: reset asserted at any point clears the pending event, pending bits, hold progress and the FSM. No event is emitted after deassertion until a fresh debounced press.

Test Plan:
Use TICK_CYCLES=20, DEBOUNCE_CYCLES=4, RST_HOLD_S=5, TEST_HOLD_S=3, evt_ready=1 unless stated.
1. botonA glitches high for 3 cycles -> no evt_valid. botonA held for 10 cycles -> exactly one evt_valid with evt_code=3, asserted 7 cycles after the rising raw edge.
2. botonReset held for 120 cycles -> hold_sec steps 1..5. evt_code=1 fires once at or before the 5th tick. hold_sec reaches 5 and stays ≤6; no second event. Release -> hold_sec=0.
3. botonReset released after 3 ticks -> no event, hold_sec returns to 0. A re-press restarts counting from 0.
4. evt_ready=0, then A and B pressed and TEST_HOLD reached:
   - The first code (3) holds stable.
   - After evt_ready=1, the codes emerge in order 3, 2, 4, each with a 1-cycle gap.
5. evt_ready=0 with A pending, then A pressed again -> evt_drop pulses once; one A event remains.
6. rst=0 asynchronously while evt_valid=1 and test is being held -> evt_valid=0 and hold_sec=0 immediately. After release: no event until a new press.
